// File: rtl/garden_pkg.sv
// Shared types and default timing constants for the garden input conditioner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package garden_pkg;

  localparam int GARDEN_DEBOUNCE_CYCLES   = 4;
  localparam int GARDEN_LONG_PRESS_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } btn_state_t;

endpackage

// File: rtl/garden_input_cond_if.sv
// Raw operator inputs and conditioned event/level outputs of the input conditioner.
// Latency: n/a (wires only).
// Backpressure: none; strobes are fire-and-forget.
interface garden_input_cond_if;

  logic       start_button;
  logic [1:0] switch;
  logic       start_pulse;
  logic       press_held;
  logic       long_pulse;
  logic [1:0] sw_stable;
  logic       mode_change;
  logic [1:0] mode_latched;

  // Consumer/driver side: supplies raw inputs, observes conditioned outputs.
  modport master (
    output start_button, switch,
    input  start_pulse, press_held, long_pulse, sw_stable, mode_change, mode_latched
  );

  // Conditioner side.
  modport slave (
    input  start_button, switch,
    output start_pulse, press_held, long_pulse, sw_stable, mode_change, mode_latched
  );

endinterface

// File: rtl/garden_sync2.sv
// 1-bit two-flop synchroniser with a configurable reset level.
// Latency: 2 clk cycles.
// Backpressure: none.
module garden_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: a plain shift through the two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser stages, reset to the input's inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/garden_input_cond.sv
// Synchronise/debounce start button and mode switch into clean strobes and levels; macro GARDEN_LONG_PRESS_EN adds long_pulse.
// Latency: raw press stable from edge 1 gives start_pulse at edge DEBOUNCE_CYCLES+3; switch change at the same edge count.
// Backpressure: none; every output is a free-running registered strobe or level.
module garden_input_cond
  import garden_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = GARDEN_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = GARDEN_LONG_PRESS_CYCLES,
  parameter bit BTN_ACTIVE_LOW    = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  garden_input_cond_if.slave  io
);

  localparam int                CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic              BTN_IDLE_LVL = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

  // Reject configurations where the long press could fire before debounce completes.
  if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_cfg
    $error("garden_input_cond: invalid DEBOUNCE_CYCLES / LONG_PRESS_CYCLES");
  end

  // ---------------------------------------------------------------------
  // Synchronisers
  // ---------------------------------------------------------------------
  logic       btn_raw_s;
  logic       btn_s;
  logic [1:0] sw_s;

  garden_sync2 #(.RST_VAL(BTN_IDLE_LVL)) u_sync_btn (
    .clk(clk), .rst_n(rst_n), .d(io.start_button), .q(btn_raw_s)
  );
  garden_sync2 #(.RST_VAL(1'b0)) u_sync_sw1 (
    .clk(clk), .rst_n(rst_n), .d(io.switch[1]), .q(sw_s[1])
  );
  garden_sync2 #(.RST_VAL(1'b0)) u_sync_sw0 (
    .clk(clk), .rst_n(rst_n), .d(io.switch[0]), .q(sw_s[0])
  );

  // 1 = pressed regardless of the button's electrical polarity.
  assign btn_s = BTN_ACTIVE_LOW ? ~btn_raw_s : btn_raw_s;

  // ---------------------------------------------------------------------
  // Switch debounce
  // ---------------------------------------------------------------------
  logic [1:0]       sw_prev_q, sw_prev_d;
  logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
  logic [1:0]       sw_stable_q, sw_stable_d;
  logic             mode_change_q, mode_change_d;

  // Accept a new switch word only after it has differed from the stable value, unchanged, long enough.
  always_comb begin
    sw_prev_d     = sw_s;
    sw_cnt_d      = sw_cnt_q;
    sw_stable_d   = sw_stable_q;
    mode_change_d = 1'b0;
    if (sw_s == sw_stable_q || sw_s != sw_prev_q) begin
      sw_cnt_d = '0;
    end else if (sw_cnt_q == CNT_LAST) begin
      sw_stable_d   = sw_s;
      mode_change_d = 1'b1;
      sw_cnt_d      = '0;
    end else begin
      sw_cnt_d = sw_cnt_q + CNT_W'(1);
    end
  end

  // Switch debounce state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_prev_q     <= 2'b00;
      sw_cnt_q      <= '0;
      sw_stable_q   <= 2'b00;
      mode_change_q <= 1'b0;
    end else begin
      sw_prev_q     <= sw_prev_d;
      sw_cnt_q      <= sw_cnt_d;
      sw_stable_q   <= sw_stable_d;
      mode_change_q <= mode_change_d;
    end
  end

  // ---------------------------------------------------------------------
  // Button FSM
  // ---------------------------------------------------------------------
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_pulse_q, start_pulse_d;
  logic             press_held_q, press_held_d;
  logic [1:0]       mode_latched_q, mode_latched_d;

  // Next state: debounce both press and release; the press strobe also snapshots the pre-update switch word.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    start_pulse_d  = 1'b0;
    mode_latched_d = mode_latched_q;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = DB_PRESS;
          cnt_d   = '0;
        end
      end
      DB_PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d        = HELD;
          cnt_d          = '0;
          start_pulse_d  = 1'b1;
          mode_latched_d = sw_stable_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end
      end
      DB_RELEASE: begin
        if (btn_s) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    press_held_d = (state_d == HELD) || (state_d == DB_RELEASE);
  end

  // Button FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      start_pulse_q  <= 1'b0;
      press_held_q   <= 1'b0;
      mode_latched_q <= 2'b00;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      start_pulse_q  <= start_pulse_d;
      press_held_q   <= press_held_d;
      mode_latched_q <= mode_latched_d;
    end
  end

  // ---------------------------------------------------------------------
  // Optional long-press detection
  // ---------------------------------------------------------------------
`ifdef GARDEN_LONG_PRESS_EN
  localparam int               HOLD_W    = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_pulse_q, long_pulse_d;

  // Count HELD cycles (saturating, kept across release bounce) so the strobe fires once per press.
  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    long_pulse_d = 1'b0;
    if (state_q == HELD) begin
      if (hold_cnt_q == HOLD_LAST) begin
        long_pulse_d = 1'b1;
      end
      if (hold_cnt_q != HOLD_MAX) begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
    end else if (state_q == DB_RELEASE && state_d == IDLE) begin
      hold_cnt_d = '0;
    end
  end

  // Long-press counter and strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q   <= '0;
      long_pulse_q <= 1'b0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      long_pulse_q <= long_pulse_d;
    end
  end

  assign io.long_pulse = long_pulse_q;
`else
  assign io.long_pulse = 1'b0;
`endif

  assign io.start_pulse  = start_pulse_q;
  assign io.press_held   = press_held_q;
  assign io.sw_stable    = sw_stable_q;
  assign io.mode_change  = mode_change_q;
  assign io.mode_latched = mode_latched_q;

endmodule
